// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - ARM-subset execute stage with forwarding, barrel shifter, ALU and iterative MUL/MLA
module ex_stage_mc #(
    parameter int WIDTH    = 32,
    parameter int IMM_W    = 24,
    parameter int MUL_BITS = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       EXE_CMD,
    input  logic             mul_en,
    input  logic             acc_en,
    input  logic [3:0]       SR_In,
    input  logic [1:0]       forward1,
    input  logic [1:0]       forward2,
    input  logic [WIDTH-1:0] Val_Rn,
    input  logic [WIDTH-1:0] Val_Rm,
    input  logic [WIDTH-1:0] Val_Ra,
    input  logic [WIDTH-1:0] MEM_ALU_Res,
    input  logic [WIDTH-1:0] WB_Value,
    input  logic             imm,
    input  logic [WIDTH-1:0] Imm_Val,
    input  logic [1:0]       shift_type,
    input  logic [4:0]       shift_amt,
    input  logic [WIDTH-1:0] PC,
    input  logic [IMM_W-1:0] Signed_imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [3:0]       SR_Out,
    output logic [WIDTH-1:0] Val_Rm_Out,
    output logic [WIDTH-1:0] Branch_Address
);
    localparam int SH_W    = $clog2(WIDTH);
    localparam int N_STEPS = WIDTH / MUL_BITS;
    localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_STEPS - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_mcand, r_mplier, r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_sav_cv;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_alu_result, r_val_rm_out;
    logic [3:0]         r_sr_out;

    logic [WIDTH-1:0]   w_rn_f, w_rm_f, w_shifted, w_val2, w_b_eff, w_res, w_acc_nxt;
    logic [SH_W-1:0]    w_amt;
    logic [SH_W:0]      w_ror_sh;
    logic [WIDTH:0]     w_sum;
    logic               w_cin, w_arith, w_c, w_v, w_accept, w_mul_last;
    logic [3:0]         w_alu_flags, w_mul_flags;

    always_comb begin
        case (forward1)
            2'b01:   w_rn_f = MEM_ALU_Res;
            2'b10:   w_rn_f = WB_Value;
            default: w_rn_f = Val_Rn;
        endcase
        case (forward2)
            2'b01:   w_rm_f = MEM_ALU_Res;
            2'b10:   w_rm_f = WB_Value;
            default: w_rm_f = Val_Rm;
        endcase
    end

    // ROR builds the wrap-around half from a left shift by WIDTH-amt; amt=0 shifts that half out entirely.
    assign w_amt    = SH_W'(shift_amt);
    assign w_ror_sh = (SH_W+1)'(WIDTH) - (SH_W+1)'(w_amt);

    always_comb begin
        case (shift_type)
            2'b00:   w_shifted = w_rm_f << w_amt;
            2'b01:   w_shifted = w_rm_f >> w_amt;
            2'b10:   w_shifted = $signed(w_rm_f) >>> w_amt;
            default: w_shifted = (w_rm_f >> w_amt) | (w_rm_f << w_ror_sh);
        endcase
    end

    assign w_val2 = imm ? Imm_Val : w_shifted;

    // Subtraction is a + ~b + cin so one adder and one overflow rule serve all four arithmetic ops.
    always_comb begin
        w_b_eff = w_val2;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        case (EXE_CMD)
            4'b0011: w_cin = SR_In[1];
            4'b0100: begin w_b_eff = ~w_val2; w_cin = 1'b1;     end
            4'b0101: begin w_b_eff = ~w_val2; w_cin = SR_In[1]; end
            4'b0010: w_cin = 1'b0;
            default: w_arith = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_rn_f} + {1'b0, w_b_eff} + (WIDTH+1)'(w_cin);

    always_comb begin
        w_res = '0;
        case (EXE_CMD)
            4'b0001: w_res = w_val2;
            4'b1001: w_res = ~w_val2;
            4'b0010, 4'b0011, 4'b0100, 4'b0101: w_res = w_sum[WIDTH-1:0];
            4'b0110: w_res = w_rn_f & w_val2;
            4'b0111: w_res = w_rn_f | w_val2;
            4'b1000: w_res = w_rn_f ^ w_val2;
            default: w_res = '0;
        endcase
    end

    assign w_c = w_arith ? w_sum[WIDTH] : SR_In[1];
    assign w_v = w_arith ? ((w_rn_f[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != w_rn_f[WIDTH-1])) : SR_In[0];
    assign w_alu_flags = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};

    assign w_acc_nxt   = r_acc + r_mcand * WIDTH'(r_mplier[MUL_BITS-1:0]);
    assign w_mul_flags = {w_acc_nxt[WIDTH-1], (w_acc_nxt == '0), r_sav_cv};
    assign w_mul_last  = (r_cnt == '0);

    assign Branch_Address = PC + WIDTH'($signed(Signed_imm));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state == S_IDLE);
        w_accept    = in_valid & (r_state == S_IDLE) & ~flush;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && mul_en) w_state_nxt = S_MUL;
                S_MUL:   if (w_mul_last)         w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_out_valid  <= 1'b0;
            r_alu_result <= '0;
            r_sr_out     <= '0;
            r_val_rm_out <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_sav_cv     <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept && !mul_en) begin
                r_out_valid  <= 1'b1;
                r_alu_result <= w_res;
                r_sr_out     <= w_alu_flags;
                r_val_rm_out <= w_rm_f;
            end else if (w_accept && mul_en) begin
                r_mcand  <= w_rn_f;
                r_mplier <= w_rm_f;
                r_acc    <= acc_en ? Val_Ra : '0;
                r_sav_cv <= SR_In[1:0];
                r_cnt    <= CNT_INIT;
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << MUL_BITS;
                r_mplier <= r_mplier >> MUL_BITS;
                if (w_mul_last) begin
                    r_out_valid  <= 1'b1;
                    r_alu_result <= w_acc_nxt;
                    r_sr_out     <= w_mul_flags;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign ALU_Result = r_alu_result;
    assign SR_Out     = r_sr_out;
    assign Val_Rm_Out = r_val_rm_out;
endmodule

// File: tb/tb_ex_stage_mc.sv
// tb/tb_ex_stage_mc.sv - directed self-checking bench for ex_stage_mc
module tb_ex_stage_mc;
    logic        CLK = 1'b0;
    logic        RST;
    logic        flush, in_valid, in_ready, mul_en, acc_en, imm, out_valid;
    logic [3:0]  EXE_CMD, SR_In, SR_Out;
    logic [1:0]  forward1, forward2, shift_type;
    logic [4:0]  shift_amt;
    logic [31:0] Val_Rn, Val_Rm, Val_Ra, MEM_ALU_Res, WB_Value, Imm_Val, PC;
    logic [31:0] ALU_Result, Val_Rm_Out, Branch_Address;
    logic [23:0] Signed_imm;

    int total = 0;
    int bad   = 0;

    ex_stage_mc #(.WIDTH(32), .IMM_W(24), .MUL_BITS(4)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .EXE_CMD(EXE_CMD), .mul_en(mul_en), .acc_en(acc_en), .SR_In(SR_In),
        .forward1(forward1), .forward2(forward2), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm),
        .Val_Ra(Val_Ra), .MEM_ALU_Res(MEM_ALU_Res), .WB_Value(WB_Value), .imm(imm),
        .Imm_Val(Imm_Val), .shift_type(shift_type), .shift_amt(shift_amt), .PC(PC),
        .Signed_imm(Signed_imm), .out_valid(out_valid), .ALU_Result(ALU_Result),
        .SR_Out(SR_Out), .Val_Rm_Out(Val_Rm_Out), .Branch_Address(Branch_Address)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0; flush = 0; in_valid = 0; mul_en = 0; acc_en = 0; imm = 0;
        EXE_CMD = 0; SR_In = 0; forward1 = 0; forward2 = 0; shift_type = 0; shift_amt = 0;
        Val_Rn = 0; Val_Rm = 0; Val_Ra = 0; MEM_ALU_Res = 0; WB_Value = 0; Imm_Val = 0;
        PC = 0; Signed_imm = 0;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_res",   ALU_Result, 32'd0);
        chk("rst_sr",    32'(SR_Out), 32'd0);
        chk("rst_rm",    Val_Rm_Out, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // ADD with Rn forwarded from MEM
        in_valid = 1; EXE_CMD = 4'b0010; forward1 = 2'b01; MEM_ALU_Res = 32'd5;
        Val_Rn = 32'd100; Val_Rm = 32'd7;
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_res",   ALU_Result, 32'd12);
        chk("add_sr",    32'(SR_Out), 32'h0);
        chk("add_rm",    Val_Rm_Out, 32'd7);

        // SUB equal operands: Z and C set
        forward1 = 2'b00; Val_Rn = 32'd3; Imm_Val = 32'd3; imm = 1; EXE_CMD = 4'b0100;
        tick();
        chk("sub_res", ALU_Result, 32'd0);
        chk("sub_sr",  32'(SR_Out), 32'h6);

        // ADC with carry-in wraps to zero
        Val_Rn = 32'hFFFFFFFF; Imm_Val = 32'd0; EXE_CMD = 4'b0011; SR_In = 4'b0010;
        tick();
        chk("adc_res", ALU_Result, 32'd0);
        chk("adc_sr",  32'(SR_Out), 32'h6);

        // AND with Rm forwarded from WB keeps C,V
        imm = 0; forward2 = 2'b10; WB_Value = 32'h0000F0F0; Val_Rn = 32'h0000FF00;
        EXE_CMD = 4'b0110; SR_In = 4'b0011;
        tick();
        chk("and_res", ALU_Result, 32'h0000F000);
        chk("and_sr",  32'(SR_Out), 32'h3);
        chk("and_rm",  Val_Rm_Out, 32'h0000F0F0);

        // bubble holds data
        in_valid = 0; forward2 = 2'b00; SR_In = 4'b0000;
        tick();
        chk("bub_valid", 32'(out_valid), 32'd0);
        chk("bub_res",   ALU_Result, 32'h0000F000);

        // shifts through MOV
        in_valid = 1; EXE_CMD = 4'b0001; Val_Rm = 32'h80000000; shift_type = 2'b10; shift_amt = 5'd4;
        tick();
        chk("asr_res", ALU_Result, 32'hF8000000);
        chk("asr_sr",  32'(SR_Out), 32'h8);
        chk("asr_rm",  Val_Rm_Out, 32'h80000000);
        Val_Rm = 32'd1; shift_type = 2'b11; shift_amt = 5'd1;
        tick();
        chk("ror_res", ALU_Result, 32'h80000000);
        Val_Rm = 32'd3; shift_type = 2'b00; shift_amt = 5'd31;
        tick();
        chk("lsl_res", ALU_Result, 32'h80000000);
        shift_type = 2'b00; shift_amt = 5'd0;

        // MUL: 8-cycle stall, C,V saved at accept
        Val_Rn = 32'h12345678; Val_Rm = 32'h10; mul_en = 1; SR_In = 4'b0011;
        tick();
        in_valid = 0; mul_en = 0; SR_In = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("mul_ready_%0d", k), 32'(in_ready), 32'd0);
            chk($sformatf("mul_valid_%0d", k), 32'(out_valid), 32'd0);
            tick();
        end
        chk("mul_done_valid", 32'(out_valid), 32'd1);
        chk("mul_res",        ALU_Result, 32'h23456780);
        chk("mul_sr",         32'(SR_Out), 32'h3);
        chk("mul_ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("mul_valid_once", 32'(out_valid), 32'd0);

        // MLA then ADD held at the input until in_ready rises
        in_valid = 1; mul_en = 1; acc_en = 1; Val_Rn = 32'hFFFFFFFF; Val_Rm = 32'd2; Val_Ra = 32'd3;
        tick();
        mul_en = 0; acc_en = 0; EXE_CMD = 4'b0010; Val_Rn = 32'd10; Val_Rm = 32'd20;
        for (int k = 0; k < 7; k++) tick();
        chk("mla_stalled", 32'(in_ready), 32'd0);
        tick();
        chk("mla_valid", 32'(out_valid), 32'd1);
        chk("mla_res",   ALU_Result, 32'd1);
        chk("mla_sr",    32'(SR_Out), 32'h0);
        chk("mla_ready", 32'(in_ready), 32'd1);
        tick();
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_res",   ALU_Result, 32'd30);
        in_valid = 0;

        // flush at step 4 of a MUL
        tick();
        in_valid = 1; mul_en = 1; Val_Rn = 32'd5; Val_Rm = 32'd5;
        tick();
        in_valid = 0; mul_en = 0;
        for (int k = 0; k < 3; k++) tick();
        flush = 1; in_valid = 1;
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        chk("fl_res",   ALU_Result, 32'd30);
        // flush in IDLE drops the offered instruction
        EXE_CMD = 4'b0001; imm = 1; Imm_Val = 32'd9;
        tick();
        chk("fl_drop_valid", 32'(out_valid), 32'd0);
        chk("fl_drop_res",   ALU_Result, 32'd30);
        flush = 0;
        tick();
        chk("mov_valid", 32'(out_valid), 32'd1);
        chk("mov_res",   ALU_Result, 32'd9);

        // async reset mid-MUL
        imm = 0; mul_en = 1; Val_Rn = 32'd7; Val_Rm = 32'd3;
        tick();
        in_valid = 0; mul_en = 0;
        tick();
        tick();
        #2;
        RST = 1'b0;
        #1;
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_res",   ALU_Result, 32'd0);
        chk("arst_sr",    32'(SR_Out), 32'd0);
        chk("arst_rm",    Val_Rm_Out, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        tick();
        chk("arst_idle", 32'(out_valid), 32'd0);

        // branch adder
        PC = 32'h100; Signed_imm = 24'hFFFFFC;
        #1;
        chk("br_neg", Branch_Address, 32'h000000FC);
        Signed_imm = 24'h000010;
        #1;
        chk("br_pos", Branch_Address, 32'h00000110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
